// File: rtl/fir_tb_pkg.sv
// fir_tb_pkg: shared constants, mode encodings, FSM states and LFSR taps for the FIR stimulus source
package fir_tb_pkg;
  localparam int NB = 11;
  localparam int NTAPS = 9;
  localparam logic [1:0] MODE_RAMP = 2'b00;
  localparam logic [1:0] MODE_LFSR = 2'b01;
  localparam logic [1:0] MODE_IMP = 2'b10;
  localparam logic [1:0] MODE_ALT = 2'b11;
  localparam int LFSR_TAP_HI = 10;
  localparam int LFSR_TAP_LO = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} state_e;
  function automatic logic [10:0] lfsr11_next(input logic [10:0] s);
    return {s[9:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction
endpackage

// File: rtl/fir_lfsr11.sv
// fir_lfsr11: 11-bit Fibonacci LFSR (x^11+x^9+1) with seed, enable and async active-low reset
module fir_lfsr11 import fir_tb_pkg::*; #(
  parameter logic [10:0] SEED = 11'h5A5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] q
);
  logic [10:0] state_q, state_d;
  always_comb state_d = en ? lfsr11_next(state_q) : state_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= SEED;
    else state_q <= state_d;
  assign q = state_q;
endmodule

// File: rtl/fir_data_src.sv
// fir_data_src: synthesizable FIR input stimulus source with ramp/LFSR/impulse/alternating streams
module fir_data_src import fir_tb_pkg::*; #(
  parameter int NB = 11,
  parameter int N_SAMPLES = 1024,
  parameter int GAP_PERIOD = 4,
  parameter int DRAIN_CYCLES = 16,
  parameter logic [10:0] LFSR_SEED = 11'h5A5,
  parameter logic [9*NB-1:0] H_INIT = '0
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          START,
  input  logic [1:0]    MODE,
  input  logic          GAP_EN,
  output logic [NB-1:0] DOUT,
  output logic          VOUT,
  output logic [NB-1:0] H0,
  output logic [NB-1:0] H1,
  output logic [NB-1:0] H2,
  output logic [NB-1:0] H3,
  output logic [NB-1:0] H4,
  output logic [NB-1:0] H5,
  output logic [NB-1:0] H6,
  output logic [NB-1:0] H7,
  output logic [NB-1:0] H8,
  output logic          BUSY,
  output logic          END_SIM
);
  localparam int SW = $clog2(GAP_PERIOD);
  localparam logic [NB-1:0] POS_MAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic [NB-1:0] NEG_MAX = {1'b1, {(NB-1){1'b0}}};
  state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic gap_en_q, gap_en_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [15:0] samp_q, samp_d, drain_q, drain_d;
  logic [NB-1:0] dout_q, dout_d, sample;
  logic vout_q, vout_d, busy_q, busy_d, end_sim_q, end_sim_d;
  logic bubble, lfsr_en;
  logic [10:0] lfsr;
  fir_lfsr11 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(CLK),
    .rst_n(RST_n),
    .en(lfsr_en),
    .q(lfsr)
  );
  always_comb begin
    bubble = gap_en_q && slot_q == SW'(GAP_PERIOD - 1);
    lfsr_en = state_q == ST_STREAM && !bubble && mode_q == MODE_LFSR;
    sample = mode_q == MODE_RAMP ? samp_q[NB-1:0] :
             mode_q == MODE_LFSR ? NB'(lfsr) :
             mode_q == MODE_IMP  ? (samp_q == '0 ? POS_MAX : '0) :
                                   (samp_q[0] ? NEG_MAX : POS_MAX);
    state_d = state_q;
    mode_d = mode_q;
    gap_en_d = gap_en_q;
    slot_d = slot_q;
    samp_d = samp_q;
    drain_d = drain_q;
    dout_d = dout_q;
    vout_d = 1'b0;
    end_sim_d = end_sim_q;
    case (state_q)
      ST_IDLE: if (START) begin
        state_d = ST_STREAM;
        mode_d = MODE;
        gap_en_d = GAP_EN;
        slot_d = '0;
        samp_d = '0;
      end
      ST_STREAM: begin
        slot_d = slot_q == SW'(GAP_PERIOD - 1) ? '0 : slot_q + 1'b1;
        if (!bubble) begin
          vout_d = 1'b1;
          dout_d = sample;
          samp_d = samp_q + 16'd1;
          if (samp_q == 16'(N_SAMPLES - 1)) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        dout_d = '0;
        drain_d = drain_q + 16'd1;
        if (drain_q == 16'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
          end_sim_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = state_q == ST_STREAM || state_d == ST_DRAIN;
  end
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      state_q <= ST_IDLE;
      mode_q <= MODE_RAMP;
      gap_en_q <= 1'b0;
      slot_q <= '0;
      samp_q <= '0;
      drain_q <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      busy_q <= 1'b0;
      end_sim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      gap_en_q <= gap_en_d;
      slot_q <= slot_d;
      samp_q <= samp_d;
      drain_q <= drain_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      busy_q <= busy_d;
      end_sim_q <= end_sim_d;
    end
  assign DOUT = dout_q;
  assign VOUT = vout_q;
  assign BUSY = busy_q;
  assign END_SIM = end_sim_q;
  assign H0 = H_INIT[0*NB +: NB];
  assign H1 = H_INIT[1*NB +: NB];
  assign H2 = H_INIT[2*NB +: NB];
  assign H3 = H_INIT[3*NB +: NB];
  assign H4 = H_INIT[4*NB +: NB];
  assign H5 = H_INIT[5*NB +: NB];
  assign H6 = H_INIT[6*NB +: NB];
  assign H7 = H_INIT[7*NB +: NB];
  assign H8 = H_INIT[8*NB +: NB];
endmodule

// File: tb/tb_fir_data_src.sv
// tb_fir_data_src: scoreboard bench for fir_data_src covering all modes, gaps, wrap, drain, reset and START handling
module tb_fir_data_src;
  import fir_tb_pkg::*;
  localparam int NS = 1030;
  localparam int GP = 4;
  localparam int DC = 16;
  localparam logic [10:0] SEED = 11'h5A5;
  localparam logic [98:0] HV = {11'h123, 11'h7FF, 11'h400, 11'h001, 11'h2AA,
                                11'h555, 11'h0F0, 11'h30F, 11'h64C};
  logic CLK = 1'b0, RST_n = 1'b0, START = 1'b0, GAP_EN = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [10:0] DOUT, H0, H1, H2, H3, H4, H5, H6, H7, H8;
  logic VOUT, BUSY, END_SIM;
  int vectors = 0, errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] h_exp[9] = '{11'h64C, 11'h30F, 11'h0F0, 11'h555, 11'h2AA,
                             11'h001, 11'h400, 11'h7FF, 11'h123};
  always #5 CLK = ~CLK;
  fir_data_src #(.NB(11), .N_SAMPLES(NS), .GAP_PERIOD(GP), .DRAIN_CYCLES(DC),
                 .LFSR_SEED(SEED), .H_INIT(HV)) dut (
    .CLK(CLK), .RST_n(RST_n), .START(START), .MODE(MODE), .GAP_EN(GAP_EN),
    .DOUT(DOUT), .VOUT(VOUT), .H0(H0), .H1(H1), .H2(H2), .H3(H3), .H4(H4),
    .H5(H5), .H6(H6), .H7(H7), .H8(H8), .BUSY(BUSY), .END_SIM(END_SIM)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [10:0] d, input logic v,
                         input logic b, input logic e);
    chk({tag, "_dout"}, 16'(DOUT), 16'(d));
    chk({tag, "_vout"}, 16'(VOUT), 16'(v));
    chk({tag, "_busy"}, 16'(BUSY), 16'(b));
    chk({tag, "_end_sim"}, 16'(END_SIM), 16'(e));
  endtask
  function automatic logic [10:0] model(input logic [1:0] m, input int k, input logic [10:0] l);
    case (m)
      MODE_RAMP: return 11'(k);
      MODE_LFSR: return l;
      MODE_IMP:  return k == 0 ? 11'd1023 : 11'd0;
      default:   return k[0] ? 11'h400 : 11'h3FF;
    endcase
  endfunction
  task automatic push_run(input logic [1:0] m);
    logic [10:0] l = SEED;
    for (int k = 0; k < NS; k++) begin
      exp_q.push_back(model(m, k, l));
      l = {l[9:0], l[10] ^ l[8]};
    end
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RST_n = 1'b0;
    #1;
    chk_out("reset", 11'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RST_n = 1'b1;
  endtask
  task automatic check_done(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk_out("done", 11'd0, 1'b0, 1'b0, 1'b1);
    end
  endtask
  task automatic run(input logic [1:0] m, input logic g, input logic hold, input int abort_at);
    logic [10:0] last, e;
    int emitted, c;
    emitted = 0;
    c = 0;
    last = 11'd0;
    @(negedge CLK);
    MODE = m;
    GAP_EN = g;
    START = 1'b1;
    push_run(m);
    @(negedge CLK);
    chk_out("start_edge", 11'd0, 1'b0, 1'b0, 1'b0);
    if (!hold) START = 1'b0;
    MODE = ~m;
    GAP_EN = ~g;
    while (emitted < NS) begin
      @(negedge CLK);
      if (g && c % GP == GP - 1) begin
        chk("bubble_vout", 16'(VOUT), 16'd0);
        chk("bubble_hold", 16'(DOUT), 16'(last));
      end else begin
        e = exp_q.pop_front();
        chk("vout", 16'(VOUT), 16'd1);
        chk("dout", 16'(DOUT), 16'(e));
        last = e;
        emitted++;
        if (emitted == abort_at + 1) begin
          RST_n = 1'b0;
          START = 1'b0;
          #1;
          chk_out("abort", 11'd0, 1'b0, 1'b0, 1'b0);
          exp_q.delete();
          @(negedge CLK);
          RST_n = 1'b1;
          return;
        end
      end
      chk("stream_busy", 16'(BUSY), 16'd1);
      chk("stream_end_sim", 16'(END_SIM), 16'd0);
      c++;
    end
    for (int j = 1; j <= DC; j++) begin
      @(negedge CLK);
      chk_out("drain", 11'd0, 1'b0, j < DC, j == DC);
    end
  endtask
  initial begin
    #1;
    chk_out("por", 11'd0, 1'b0, 1'b0, 1'b0);
    chk("h0", 16'(H0), 16'(h_exp[0]));
    chk("h1", 16'(H1), 16'(h_exp[1]));
    chk("h2", 16'(H2), 16'(h_exp[2]));
    chk("h3", 16'(H3), 16'(h_exp[3]));
    chk("h4", 16'(H4), 16'(h_exp[4]));
    chk("h5", 16'(H5), 16'(h_exp[5]));
    chk("h6", 16'(H6), 16'(h_exp[6]));
    chk("h7", 16'(H7), 16'(h_exp[7]));
    chk("h8", 16'(H8), 16'(h_exp[8]));
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk_out("idle", 11'd0, 1'b0, 1'b0, 1'b0);
    end
    run(MODE_RAMP, 1'b0, 1'b0, -1);
    START = 1'b1;
    check_done(5);
    START = 1'b0;
    do_reset();
    run(MODE_RAMP, 1'b1, 1'b0, -1);
    do_reset();
    run(MODE_LFSR, 1'b0, 1'b0, -1);
    do_reset();
    run(MODE_IMP, 1'b1, 1'b0, -1);
    do_reset();
    run(MODE_ALT, 1'b0, 1'b1, -1);
    check_done(20);
    START = 1'b0;
    do_reset();
    run(MODE_RAMP, 1'b0, 1'b0, 2);
    run(MODE_RAMP, 1'b0, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
